nios_ii_sample_reader: RTL and testbench
========================================

Name: nios_ii_sample_reader

Overview:
- Playback engine for the 17-bit sample RAM that the NIOS fills through its write-address/write-data PIO ports.
- The NIOS programs start and end addresses and a run/loop control over an Avalon-MM slave.
- On each sample_tick the block reads one word from the RAM's synchronous read port and presents it on sample_out with a one-cycle sample_valid pulse for the audio output stage.

Parameters:
- ADDR_W, 17, sample RAM address width; matches the write-address PIO width.
- DATA_W, 16, sample word width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  Avalon register select.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; combinational, zero wait states, unused bits zero.
- sample_tick  in  1  one-cycle sample-rate strobe.
- mem_rd_en  out  1  RAM read enable.
- mem_rd_address  out  ADDR_W  RAM read address.
- mem_rd_data  in  DATA_W  RAM read data, valid the cycle after mem_rd_en.
- sample_out  out  DATA_W  last fetched sample, held between updates.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- playing  out  1  high while the state is not IDLE.

Behaviour:
- Reset: all registers and outputs are 0; the state is IDLE.
- Register map (a write needs chipselect and write_n low):
  - 0 START: rw, bits [ADDR_W-1:0].
  - 1 END: rw, inclusive last address.
  - 2 CTRL: rw. Bit0 RUN, bit1 LOOP.
  - 3 STATUS: bit0 PLAYING (ro). Bit1 DONE (sticky, write 1 clears). Bit2 OVERRUN (sticky, write 1 clears).
  - 4 POS: ro, current address.
  - 5-7: read 0, writes ignored.
- FSM states are IDLE, ARMED and FETCH.
- IDLE:
  - A write to CTRL with RUN=1 loads pos<=START and enters ARMED next cycle.
  - Reads of CTRL return the stored bits.
- ARMED:
  - On sample_tick, drive mem_rd_en=1 and mem_rd_address=pos for that cycle, then go to FETCH.
- FETCH (exactly one cycle):
  - sample_out<=mem_rd_data and sample_valid=1 on the next edge.
  - If pos==END and LOOP=1: pos<=START and return to ARMED.
  - If pos==END and LOOP=0: clear RUN, set DONE, go to IDLE.
  - Otherwise pos<=pos+1 modulo 2^ADDR_W and return to ARMED.
- Latency: a tick at cycle t gives mem_rd_en at t and sample_valid at t+2.
- Wrap: START>END is legal. Playback runs through 2^ADDR_W-1, wraps to 0, and stops at END.
- A tick while in FETCH, or a tick in the same cycle as the start write, is dropped and sets OVERRUN.
- A write of RUN=0 while ARMED or FETCH goes to IDLE next cycle:
  - Any in-flight read is discarded (no sample_valid).
  - sample_out holds its value and DONE is not set.
- A write of RUN=1 while already running re-arms from START.
- Writes to START/END during playback take effect at the next comparison or reload.
- A DONE set in the same cycle as a DONE-clear write: the set wins.
- Asserting reset_n mid-playback returns to IDLE immediately and zeroes sample_out.

Decomposition:
- Shared package nios_ii_sample_reader_pkg:
  - register offset constants REG_START, REG_END, REG_CTRL, REG_STATUS, REG_POS;
  - CTRL/STATUS bit indices;
  - the state enum.
- No sub-module is needed; the register file, FSM and address counter fit in one module.

Test Plan:
- START=0x10, END=0x12, LOOP=0, RAM[a]=a*3, ticks every 8 cycles → samples 0x30, 0x33, 0x36. Then DONE=1, playing=0, CTRL reads 0, and further ticks give no sample_valid.
- START=0x1FFFE, END=0x00001, LOOP=0 → addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001, then DONE.
- START=5, END=6, LOOP=1, 6 ticks → addresses 5, 6, 5, 6, 5, 6; DONE stays 0.
- Tick at t and t+1 → one read at t, sample_valid at t+2, OVERRUN=1. Writing STATUS=0x4 clears it.
- Write RUN=0 on the cycle after mem_rd_en → no sample_valid, sample_out unchanged, state IDLE, POS frozen.
- Assert reset_n mid-playback → all outputs 0 asynchronously. After release, readdata for every register reads 0.

Source files
------------

// File: rtl/nios_ii_sample_reader_pkg.sv
// Shared definitions for the sample reader: register map, CTRL/STATUS bit
// positions and the playback state encoding.
package nios_ii_sample_reader_pkg;

  // Avalon register offsets
  localparam logic [2:0] REG_START  = 3'd0;
  localparam logic [2:0] REG_END    = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_POS    = 3'd4;

  // CTRL bit positions
  localparam int unsigned CTRL_RUN  = 0;
  localparam int unsigned CTRL_LOOP = 1;

  // STATUS bit positions
  localparam int unsigned STAT_PLAYING = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_OVERRUN = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FETCH = 2'd2
  } state_t;

endpackage

// File: rtl/nios_ii_sample_reader_if.sv
// Avalon-MM register port of the sample reader (zero wait states).
interface nios_ii_sample_reader_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/nios_ii_sample_reader.sv
// Sample RAM playback engine: the NIOS programs a START..END address window
// and RUN/LOOP control; each sample_tick fetches one word from the RAM's
// synchronous read port and presents it with a one-cycle sample_valid.
module nios_ii_sample_reader
  import nios_ii_sample_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios_ii_sample_reader_if.slave avs,
  input  logic                 sample_tick,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_address,
  input  logic [DATA_W-1:0]    mem_rd_data,
  output logic [DATA_W-1:0]    sample_out,
  output logic                 sample_valid,
  output logic                 playing
);

  state_t state, state_next;

  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] pos;
  logic              run;
  logic              loop_en;
  logic              done;
  logic              overrun;

  logic wr;
  logic ctrl_wr;
  logic status_wr;
  logic start_cmd;
  logic stop_cmd;
  logic at_end;
  logic tick_drop;

  logic load_pos;
  logic inc_pos;
  logic finish;
  logic deliver;

  logic [31:0] rdata;
  logic        unused_wdata;

  assign wr        = avs.chipselect && !avs.write_n;
  assign ctrl_wr   = wr && (avs.address == REG_CTRL);
  assign status_wr = wr && (avs.address == REG_STATUS);
  assign start_cmd = ctrl_wr && avs.writedata[CTRL_RUN];
  assign stop_cmd  = ctrl_wr && !avs.writedata[CTRL_RUN];
  assign at_end    = (pos == end_addr);
  // Ticks that cannot be serviced: one landing on the fetch cycle, or one
  // coinciding with the start write.
  assign tick_drop = sample_tick && ((state == S_FETCH) || start_cmd);

  assign unused_wdata   = ^avs.writedata[31:ADDR_W];
  assign mem_rd_address = pos;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic plus the datapath decisions taken on this edge.
  // A CTRL write while running overrides any in-flight fetch, so the read
  // in FETCH is only delivered when no CTRL write is present.
  always_comb begin
    state_next = state;
    load_pos   = 1'b0;
    inc_pos    = 1'b0;
    finish     = 1'b0;
    deliver    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_cmd) begin
          load_pos   = 1'b1;
          state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (start_cmd)        load_pos   = 1'b1;
        else if (stop_cmd)    state_next = S_IDLE;
        else if (sample_tick) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (start_cmd) begin
          load_pos   = 1'b1;
          state_next = S_ARMED;
        end else if (stop_cmd) begin
          state_next = S_IDLE;
        end else begin
          deliver = 1'b1;
          if (at_end && loop_en) begin
            load_pos   = 1'b1;
            state_next = S_ARMED;
          end else if (at_end) begin
            finish     = 1'b1;
            state_next = S_IDLE;
          end else begin
            inc_pos    = 1'b1;
            state_next = S_ARMED;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: RAM read strobe and playing flag
  always_comb begin
    mem_rd_en = 1'b0;
    playing   = (state != S_IDLE);
    if (state == S_ARMED && sample_tick && !ctrl_wr) mem_rd_en = 1'b1;
  end

  // Address window registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_addr <= '0;
      end_addr   <= '0;
    end else if (wr) begin
      if (avs.address == REG_START) start_addr <= avs.writedata[ADDR_W-1:0];
      if (avs.address == REG_END)   end_addr   <= avs.writedata[ADDR_W-1:0];
    end
  end

  // CTRL bits; RUN self-clears when a non-looping pass completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run     <= 1'b0;
      loop_en <= 1'b0;
    end else if (ctrl_wr) begin
      run     <= avs.writedata[CTRL_RUN];
      loop_en <= avs.writedata[CTRL_LOOP];
    end else if (finish) begin
      run <= 1'b0;
    end
  end

  // Sticky STATUS flags; a set on the same edge as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (finish)                                       done <= 1'b1;
      else if (status_wr && avs.writedata[STAT_DONE])   done <= 1'b0;
      if (tick_drop)                                    overrun <= 1'b1;
      else if (status_wr && avs.writedata[STAT_OVERRUN]) overrun <= 1'b0;
    end
  end

  // Playback address counter, wraps modulo 2^ADDR_W
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     pos <= '0;
    else if (load_pos) pos <= start_addr;
    else if (inc_pos)  pos <= pos + 1'b1;
  end

  // Sample capture and valid pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= deliver;
      if (deliver) sample_out <= mem_rd_data;
    end
  end

  // Combinational register read mux
  always_comb begin
    rdata = '0;
    case (avs.address)
      REG_START:  rdata[ADDR_W-1:0] = start_addr;
      REG_END:    rdata[ADDR_W-1:0] = end_addr;
      REG_CTRL: begin
        rdata[CTRL_RUN]  = run;
        rdata[CTRL_LOOP] = loop_en;
      end
      REG_STATUS: begin
        rdata[STAT_PLAYING] = playing;
        rdata[STAT_DONE]    = done;
        rdata[STAT_OVERRUN] = overrun;
      end
      REG_POS:    rdata[ADDR_W-1:0] = pos;
      default:    rdata = '0;
    endcase
  end

  assign avs.readdata = rdata;

endmodule

// File: tb/tb_nios_ii_sample_reader.sv
// Directed bench for nios_ii_sample_reader. Stimulus is driven on the
// falling edge; a RAM model returns addr*3 one cycle after mem_rd_en.
module tb_nios_ii_sample_reader;
  import nios_ii_sample_reader_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        mem_rd_en;
  logic [16:0] mem_rd_address;
  logic [15:0] mem_rd_data = '0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        playing;

  int errors = 0;
  int checks = 0;

  logic [16:0] rd_q[$];
  logic [15:0] smp_q[$];
  logic [31:0] rv;

  nios_ii_sample_reader_if avs();

  nios_ii_sample_reader #(.ADDR_W(17), .DATA_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs            (avs),
    .sample_tick    (sample_tick),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_address (mem_rd_address),
    .mem_rd_data    (mem_rd_data),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .playing        (playing)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [16:0] a);
    logic [18:0] p;
    p = 19'(a) * 19'd3;
    return p[15:0];
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram_word(mem_rd_address);

  // Record every RAM read and every delivered sample
  always @(negedge clk) begin
    #2;
    if (mem_rd_en)    rd_q.push_back(mem_rd_address);
    if (sample_valid) smp_q.push_back(sample_out);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge
  task automatic avs_write(input logic [2:0] a, input logic [31:0] d);
    avs.address = a; avs.writedata = d; avs.chipselect = 1'b1; avs.write_n = 1'b0;
    @(negedge clk);
    avs.chipselect = 1'b0; avs.write_n = 1'b1;
  endtask

  task automatic avs_read(input logic [2:0] a, output logic [31:0] d);
    avs.address = a; avs.chipselect = 1'b1; avs.write_n = 1'b1;
    #1 d = avs.readdata;
    @(negedge clk);
    avs.chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_pulse();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic clear_log();
    rd_q.delete();
    smp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [16:0] exp_a[$];
    logic [15:0] exp_s[$];

    avs.address = '0; avs.chipselect = 1'b0; avs.write_n = 1'b1; avs.writedata = '0;
    idle(2);
    reset_n = 1'b1;
    idle(1);

    // Reset state
    check("rst playing", 32'(playing), 32'h0);
    check("rst sample_out", 32'(sample_out), 32'h0);
    check("rst sample_valid", 32'(sample_valid), 32'h0);
    for (int unsigned r = 0; r < 8; r++) begin
      avs_read(3'(r), rv);
      check($sformatf("rst reg%0d", r), rv, 32'h0);
    end

    // Single pass 0x10..0x12, no loop
    avs_write(REG_START, 32'h10);
    avs_write(REG_END, 32'h12);
    avs_write(REG_CTRL, 32'h1);
    check("t1 playing", 32'(playing), 32'h1);
    clear_log();
    sample_tick = 1'b1;
    #1;
    check("t1 rd_en at t", 32'(mem_rd_en), 32'h1);
    check("t1 rd_addr at t", 32'(mem_rd_address), 32'h10);
    @(negedge clk);
    sample_tick = 1'b0;
    check("t1 valid at t+1", 32'(sample_valid), 32'h0);
    @(negedge clk);
    check("t1 valid at t+2", 32'(sample_valid), 32'h1);
    check("t1 sample at t+2", 32'(sample_out), 32'h30);
    idle(6);
    repeat (2) begin tick_pulse(); idle(7); end
    exp_a = '{17'h10, 17'h11, 17'h12};
    exp_s = '{16'h30, 16'h33, 16'h36};
    check("t1 reads", rd_q.size(), 3);
    check("t1 samples", smp_q.size(), 3);
    for (int i = 0; i < 3 && i < rd_q.size() && i < smp_q.size(); i++) begin
      check($sformatf("t1 addr%0d", i), 32'(rd_q[i]), 32'(exp_a[i]));
      check($sformatf("t1 smp%0d", i), 32'(smp_q[i]), 32'(exp_s[i]));
    end
    avs_read(REG_STATUS, rv); check("t1 status done", rv, 32'h2);
    check("t1 playing end", 32'(playing), 32'h0);
    avs_read(REG_CTRL, rv); check("t1 ctrl cleared", rv, 32'h0);
    clear_log();
    repeat (2) begin tick_pulse(); idle(3); end
    check("t1 idle no samples", smp_q.size(), 0);
    check("t1 idle no reads", rd_q.size(), 0);
    avs_write(REG_STATUS, 32'h2);
    avs_read(REG_STATUS, rv); check("t1 done cleared", rv, 32'h0);

    // Wrapping window 0x1FFFE..0x00001
    avs_write(REG_START, 32'h1FFFE);
    avs_write(REG_END, 32'h1);
    avs_write(REG_CTRL, 32'h1);
    clear_log();
    repeat (4) begin tick_pulse(); idle(7); end
    exp_a = '{17'h1FFFE, 17'h1FFFF, 17'h0, 17'h1};
    exp_s = '{16'hFFFA, 16'hFFFD, 16'h0, 16'h3};
    check("t2 reads", rd_q.size(), 4);
    check("t2 samples", smp_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size() && i < smp_q.size(); i++) begin
      check($sformatf("t2 addr%0d", i), 32'(rd_q[i]), 32'(exp_a[i]));
      check($sformatf("t2 smp%0d", i), 32'(smp_q[i]), 32'(exp_s[i]));
    end
    avs_read(REG_STATUS, rv); check("t2 status done", rv, 32'h2);
    avs_write(REG_STATUS, 32'h2);

    // Looping window 5..6
    avs_write(REG_START, 32'h5);
    avs_write(REG_END, 32'h6);
    avs_write(REG_CTRL, 32'h3);
    clear_log();
    repeat (6) begin tick_pulse(); idle(7); end
    exp_a = '{17'h5, 17'h6, 17'h5, 17'h6, 17'h5, 17'h6};
    check("t3 reads", rd_q.size(), 6);
    for (int i = 0; i < 6 && i < rd_q.size(); i++)
      check($sformatf("t3 addr%0d", i), 32'(rd_q[i]), 32'(exp_a[i]));
    avs_read(REG_STATUS, rv); check("t3 status no done", rv, 32'h1);
    avs_read(REG_CTRL, rv); check("t3 ctrl", rv, 32'h3);
    avs_read(REG_POS, rv); check("t3 pos reloaded", rv, 32'h5);
    avs_write(REG_CTRL, 32'h0);
    idle(1);
    check("t3 stopped", 32'(playing), 32'h0);

    // Back-to-back ticks: second one is dropped and flags overrun
    avs_write(REG_START, 32'h20);
    avs_write(REG_END, 32'h2F);
    avs_write(REG_CTRL, 32'h1);
    idle(2);
    clear_log();
    sample_tick = 1'b1;
    idle(2);
    sample_tick = 1'b0;
    idle(4);
    check("t4 reads", rd_q.size(), 1);
    check("t4 samples", smp_q.size(), 1);
    if (smp_q.size() > 0) check("t4 sample", 32'(smp_q[0]), 32'h60);
    avs_read(REG_STATUS, rv); check("t4 overrun set", rv, 32'h5);
    avs_write(REG_STATUS, 32'h4);
    avs_read(REG_STATUS, rv); check("t4 overrun clr", rv, 32'h1);

    // Stop during the fetch cycle: in-flight read discarded
    clear_log();
    sample_tick = 1'b1;
    #1 check("t5 rd_en", 32'(mem_rd_en), 32'h1);
    @(negedge clk);
    sample_tick = 1'b0;
    avs_write(REG_CTRL, 32'h0);
    idle(3);
    check("t5 reads", rd_q.size(), 1);
    check("t5 no sample", smp_q.size(), 0);
    check("t5 sample held", 32'(sample_out), 32'h60);
    check("t5 idle", 32'(playing), 32'h0);
    avs_read(REG_POS, rv); check("t5 pos frozen", rv, 32'h21);
    avs_read(REG_STATUS, rv); check("t5 no done", rv, 32'h0);

    // Unmapped register writes are ignored
    avs_write(3'd5, 32'hFFFF_FFFF);
    avs_read(3'd5, rv); check("unmapped reg5", rv, 32'h0);

    // Asynchronous reset mid-playback
    avs_write(REG_START, 32'h40);
    avs_write(REG_END, 32'h4F);
    avs_write(REG_CTRL, 32'h1);
    tick_pulse();
    idle(3);
    check("t6 sample pre-rst", 32'(sample_out), 32'hC0);
    sample_tick = 1'b1;
    #1 check("t6 rd_en pre-rst", 32'(mem_rd_en), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("t6 rst rd_en", 32'(mem_rd_en), 32'h0);
    check("t6 rst playing", 32'(playing), 32'h0);
    check("t6 rst sample_out", 32'(sample_out), 32'h0);
    check("t6 rst rd_addr", 32'(mem_rd_address), 32'h0);
    sample_tick = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int unsigned r = 0; r < 8; r++) begin
      avs_read(3'(r), rv);
      check($sformatf("t6 reg%0d", r), rv, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
